// File: rtl/mos_pkg.sv
// Shared constants and state encoding for the MOSFET sweep sequencer and its
// combinational I_D/G_M evaluator.
package mos_pkg;

   localparam int VTH    = 1;
   localparam int V_W    = 3;
   localparam int OUT_W  = 6;
   localparam int CALC_W = 10;
   localparam int PT_W   = 2 * V_W;

   localparam logic [CALC_W-1:0] CLAMP_MAX = CALC_W'((1 << OUT_W) - 1);
   localparam logic [CALC_W-1:0] VTH_C     = CALC_W'(VTH);
   localparam logic [PT_W-1:0]   PT_LAST   = '1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/mos_eval.sv
// Combinational square-law MOSFET model: I_D and G_M for one (W, V_GS, V_DS)
// point, computed in 10-bit unsigned with floored division and clamped.
module mos_eval
   import mos_pkg::*;
(
   input  logic [V_W-1:0]   w,
   input  logic [V_W-1:0]   vgs,
   input  logic [V_W-1:0]   vds,
   output logic [OUT_W-1:0] id,
   output logic [OUT_W-1:0] gm
);

   function automatic logic [OUT_W-1:0] clamp(input logic [CALC_W-1:0] x);
      return (x > CLAMP_MAX) ? CLAMP_MAX[OUT_W-1:0] : x[OUT_W-1:0];
   endfunction

   logic [CALC_W-1:0] w_c, vgs_c, vds_c;
   logic [CALC_W-1:0] vov, id_raw, gm_raw;

   assign w_c   = CALC_W'(w);
   assign vgs_c = CALC_W'(vgs);
   assign vds_c = CALC_W'(vds);

   always_comb begin
      vov    = '0;
      id_raw = '0;
      gm_raw = '0;
      if (vgs_c > VTH_C) begin
         vov = vgs_c - VTH_C;
         // Triode only when Vov > V_DS, so 2*Vov*V_DS - V_DS^2 cannot underflow
         if (vov > vds_c) begin
            id_raw = (w_c * (((vov * vds_c) << 1) - (vds_c * vds_c))) / CALC_W'(3);
            gm_raw = ((w_c * vds_c) << 1) / CALC_W'(3);
         end else begin
            id_raw = (w_c * (vov * vov)) / CALC_W'(3);
            gm_raw = ((w_c * vov) << 1) / CALC_W'(3);
         end
      end
   end

   assign id = clamp(id_raw);
   assign gm = clamp(gm_raw);

endmodule

// File: rtl/mos_sweep_ctrl.sv
// Sweep sequencer: walks V_GS x V_DS over 64 points for a latched width,
// streams results over valid/ready and tracks the maximum-I_D point.
module mos_sweep_ctrl
   import mos_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [V_W-1:0]   W,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [V_W-1:0]   out_vgs,
   output logic [V_W-1:0]   out_vds,
   output logic [OUT_W-1:0] out_id,
   output logic [OUT_W-1:0] out_gm,
   output logic             done,
   output logic [OUT_W-1:0] max_id,
   output logic [V_W-1:0]   max_vgs,
   output logic [V_W-1:0]   max_vds
);

   state_t            state, state_nxt;
   logic [V_W-1:0]    w_lat;
   logic [PT_W-1:0]   pt;
   logic              go, load, accept;
   logic [OUT_W-1:0]  id_nxt, gm_nxt;

   mos_eval u_eval (
      .w   (w_lat),
      .vgs (pt[PT_W-1:V_W]),
      .vds (pt[V_W-1:0]),
      .id  (id_nxt),
      .gm  (gm_nxt)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      go        = 1'b0;
      load      = 1'b0;
      busy      = 1'b0;
      accept    = out_valid && out_ready;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               go        = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            // Refill the result register when empty or emptying this cycle
            load = !out_valid || out_ready;
            if (load && (pt == PT_LAST)) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (accept) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         w_lat     <= '0;
         pt        <= '0;
         out_valid <= 1'b0;
         out_vgs   <= '0;
         out_vds   <= '0;
         out_id    <= '0;
         out_gm    <= '0;
         done      <= 1'b0;
         max_id    <= '0;
         max_vgs   <= '0;
         max_vds   <= '0;
      end else begin
         done <= (state == DRAIN) && accept;
         if (go) begin
            w_lat     <= W;
            pt        <= '0;
            out_valid <= 1'b0;
            max_id    <= '0;
            max_vgs   <= '0;
            max_vds   <= '0;
         end else if (load) begin
            out_valid <= 1'b1;
            out_vgs   <= pt[PT_W-1:V_W];
            out_vds   <= pt[V_W-1:0];
            out_id    <= id_nxt;
            out_gm    <= gm_nxt;
            pt        <= pt + PT_W'(1);
            // Strict compare keeps the earliest point on ties
            if (id_nxt > max_id) begin
               max_id  <= id_nxt;
               max_vgs <= pt[PT_W-1:V_W];
               max_vds <= pt[V_W-1:0];
            end
         end else if (accept) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mos_sweep_ctrl.sv
// Directed + randomized bench for mos_sweep_ctrl against a square-law
// reference model computed with plain integer arithmetic.
module tb_mos_sweep_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [2:0] W = 3'd0;
   logic       out_ready = 1'b0;
   logic       busy, out_valid, done;
   logic [2:0] out_vgs, out_vds, max_vgs, max_vds;
   logic [5:0] out_id, out_gm, max_id;

   int checks = 0;
   int failures = 0;
   int got_id[64];
   int got_gm[64];
   int last_hs;

   mos_sweep_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .W         (W),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_vgs   (out_vgs),
      .out_vds   (out_vds),
      .out_id    (out_id),
      .out_gm    (out_gm),
      .done      (done),
      .max_id    (max_id),
      .max_vgs   (max_vgs),
      .max_vds   (max_vds)
   );

   always #5 clk = ~clk;

   function automatic int clampv(int x);
      return (x > 63) ? 63 : x;
   endfunction

   function automatic int ref_id(int w, int vgs, int vds);
      int vov;
      if (vgs <= 1) return 0;
      vov = vgs - 1;
      if (vov > vds) return clampv(w * (2 * vov * vds - vds * vds) / 3);
      return clampv(w * vov * vov / 3);
   endfunction

   function automatic int ref_gm(int w, int vgs, int vds);
      int vov;
      if (vgs <= 1) return 0;
      vov = vgs - 1;
      if (vov > vds) return clampv(2 * w * vds / 3);
      return clampv(2 * w * vov / 3);
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_fields"}, {out_vgs, out_vds, out_id, out_gm}, 0);
      check({tag, "_max"}, {max_id, max_vgs, max_vds}, 0);
   endtask

   // mode 0: ready held; 1: random ready; 2: 5-cycle stall at point 20;
   // 3: ready held, random start pulses and W changes while running
   task automatic run_sweep(input logic [2:0] w, input int mode);
      int hs, cyc, stall, emax, evgs, evds, v;
      logic hold;
      logic [17:0] saved;
      emax = 0; evgs = 0; evds = 0;
      for (int p = 0; p < 64; p++) begin
         v = ref_id(w, p / 8, p % 8);
         if (v > emax) begin emax = v; evgs = p / 8; evds = p % 8; end
      end
      W = w;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_busy", busy, 1);
      check("start_valid", out_valid, 0);
      hs = 0; cyc = 0; stall = 0; hold = 1'b0; saved = '0;
      while (hs < 64 && cyc < 1000) begin
         case (mode)
            1: out_ready = ($urandom_range(0, 3) != 0);
            2: begin
               if (hs == 20 && stall < 5) begin out_ready = 1'b0; stall++; end
               else out_ready = 1'b1;
            end
            3: begin
               out_ready = 1'b1;
               start = $urandom_range(0, 1) != 0;
               W = 3'($urandom);
            end
            default: out_ready = 1'b1;
         endcase
         if (hold) check("hold_stable", {out_vgs, out_vds, out_id, out_gm}, saved);
         check("busy_run", busy, 1);
         check("done_low", done, 0);
         if (out_valid && out_ready) begin
            check("pt_vgs", out_vgs, hs / 8);
            check("pt_vds", out_vds, hs % 8);
            check("pt_id", out_id, ref_id(w, hs / 8, hs % 8));
            check("pt_gm", out_gm, ref_gm(w, hs / 8, hs % 8));
            got_id[hs] = out_id;
            got_gm[hs] = out_gm;
            hs++;
         end
         hold = out_valid && !out_ready;
         saved = {out_vgs, out_vds, out_id, out_gm};
         tick();
         cyc++;
      end
      start = 1'b0;
      last_hs = hs;
      check("handshakes", hs, 64);
      if (mode == 0 || mode == 3) check("cycles_full_rate", cyc, 65);
      if (mode == 2) check("stall_cycles", stall, 5);
      check("done_pulse", done, 1);
      check("done_busy", busy, 0);
      check("done_valid", out_valid, 0);
      check("max_id", max_id, emax);
      check("max_vgs", max_vgs, evgs);
      check("max_vds", max_vds, evds);
      tick();
      check("done_once", done, 0);
      check("max_hold", max_id, emax);
   endtask

   initial begin
      int cyc, hs;
      rst_n = 1'b0;
      tick();
      tick();
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();
      check_all_zero("idle");

      // W=3 directed points
      run_sweep(3'd3, 0);
      check("w3_p41_id", got_id[33], 5);
      check("w3_p41_gm", got_gm[33], 2);
      check("w3_p35_id", got_id[29], 4);
      check("w3_p35_gm", got_gm[29], 4);
      for (int i = 8; i < 16; i++) check("w3_cutoff", got_id[i] + got_gm[i], 0);

      // W=7 with random backpressure: clamp and max position
      run_sweep(3'd7, 1);
      check("w7_p77_id", got_id[63], 63);
      check("w7_p77_gm", got_gm[63], 28);
      check("w7_maxid", max_id, 63);
      check("w7_maxvgs", max_vgs, 7);
      check("w7_maxvds", max_vds, 3);

      // W=0: all zero
      run_sweep(3'd0, 0);
      check("w0_count", last_hs, 64);
      check("w0_max", {max_id, max_vgs, max_vds}, 0);

      run_sweep(3'd6, 2);
      run_sweep(3'd4, 3);
      for (int k = 0; k < 2; k++) run_sweep(3'($urandom_range(1, 7)), 1);

      // Reset at point 20
      W = 3'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      out_ready = 1'b1;
      hs = 0; cyc = 0;
      while (hs < 20 && cyc < 200) begin
         if (out_valid && out_ready) hs++;
         tick();
         cyc++;
      end
      check("pre_reset_hs", hs, 20);
      check("pre_reset_vgs", out_vgs, 2);
      check("pre_reset_vds", out_vds, 4);
      rst_n = 1'b0;
      tick();
      check_all_zero("midreset");
      rst_n = 1'b1;
      tick();
      check_all_zero("post_reset_idle");
      run_sweep(3'd5, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
